// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-to-ALU front end: FSM state encoding and ALU opcodes.
// The S_TX_FLG state exists only when UART_ALU_IF_FLAGS_EN is defined.
package uart_alu_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
`ifdef UART_ALU_IF_FLAGS_EN
        S_TX_RES  = 3'd4,
        S_TX_FLG  = 3'd5
`else
        S_TX_RES  = 3'd4
`endif
    } state_e;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'h24;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'h27;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'h03;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'h02;

endpackage

// File: rtl/uart_alu_interface_if.sv
// Bus bundle between the UART front end, the UART rx/tx pair and the ALU.
// master = front end (drives o_*), slave = surrounding top level or bench.
interface uart_alu_interface_if
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    // i_rx_done and i_tx_done are single-cycle pulses; o_tx_start is a single-cycle
    // pulse and o_tx_data stays stable until the matching i_tx_done arrives.
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_alu_zero;
    logic               i_alu_negative;
    logic               i_alu_carry;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_alu_data_A;
    logic [NB_DATA-1:0] o_alu_data_B;
    logic [NB_OP-1:0]   o_alu_OP;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    state_e             o_dbg_state;

    modport master (
        input  i_rx_data, i_rx_done, i_alu_result, i_alu_zero, i_alu_negative,
               i_alu_carry, i_tx_done,
        output o_alu_data_A, o_alu_data_B, o_alu_OP, o_tx_data, o_tx_start, o_dbg_state
    );

    modport slave (
        output i_rx_data, i_rx_done, i_alu_result, i_alu_zero, i_alu_negative,
               i_alu_carry, i_tx_done,
        input  o_alu_data_A, o_alu_data_B, o_alu_OP, o_tx_data, o_tx_start, o_dbg_state
    );

endinterface

// File: rtl/uart_alu_interface.sv
// Collects A, B and opcode bytes from the UART receiver, holds them on the ALU, and
// sends the result byte (plus a flags byte when UART_ALU_IF_FLAGS_EN is defined).
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input logic                  i_clk,
    input logic                  i_reset,
    uart_alu_interface_if.master bus
);

    state_e             state_q;
    logic [NB_DATA-1:0] a_q;
    logic [NB_DATA-1:0] b_q;
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] tx_data_q;
    logic               tx_start_q;

`ifdef UART_ALU_IF_FLAGS_EN
    logic [2:0] flags_q;
`else
    logic unused_flags;
    assign unused_flags = ^{bus.i_alu_carry, bus.i_alu_negative, bus.i_alu_zero};
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
`ifdef UART_ALU_IF_FLAGS_EN
            flags_q    <= '0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                S_WAIT_A: begin
                    if (bus.i_rx_done) begin
                        a_q     <= bus.i_rx_data;
                        state_q <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (bus.i_rx_done) begin
                        b_q     <= bus.i_rx_data;
                        state_q <= S_WAIT_OP;
                    end
                end
                S_WAIT_OP: begin
                    if (bus.i_rx_done) begin
                        op_q    <= bus.i_rx_data[NB_OP-1:0];
                        state_q <= S_EXEC;
                    end
                end
                // ALU inputs settled on the previous edge, so the result is valid now.
                S_EXEC: begin
                    tx_data_q  <= bus.i_alu_result;
                    tx_start_q <= 1'b1;
`ifdef UART_ALU_IF_FLAGS_EN
                    flags_q    <= {bus.i_alu_carry, bus.i_alu_negative, bus.i_alu_zero};
`endif
                    state_q    <= S_TX_RES;
                end
                S_TX_RES: begin
                    if (bus.i_tx_done) begin
`ifdef UART_ALU_IF_FLAGS_EN
                        tx_data_q  <= {{(NB_DATA-3){1'b0}}, flags_q};
                        tx_start_q <= 1'b1;
                        state_q    <= S_TX_FLG;
`else
                        state_q    <= S_WAIT_A;
`endif
                    end
                end
`ifdef UART_ALU_IF_FLAGS_EN
                S_TX_FLG: begin
                    if (bus.i_tx_done) begin
                        state_q <= S_WAIT_A;
                    end
                end
`endif
                default: state_q <= S_WAIT_A;
            endcase
        end
    end

    assign bus.o_alu_data_A = a_q;
    assign bus.o_alu_data_B = b_q;
    assign bus.o_alu_OP     = op_q;
    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_tx_start   = tx_start_q;
    assign bus.o_dbg_state  = state_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed plus randomized frames against a behavioural ALU/flags reference model.
// Honours UART_ALU_IF_FLAGS_EN to expect the extra flags byte.
module tb_uart_alu_interface;
    import uart_alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks      = 0;
    int   errors      = 0;
    int   pulse_count = 0;
    int   exp_pulses  = 0;

    always #5 clk = ~clk;

    uart_alu_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    uart_alu_interface #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Reference ALU from plain arithmetic: returns {carry, result}.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        int       sum;
        logic [7:0] r;
        logic       c;
        r = 8'h00;
        c = 1'b0;
        case (op)
            6'h20: begin sum = int'(a) + int'(b); r = 8'(sum % 256); c = (sum > 255); end
            6'h22: begin sum = int'(a) - int'(b) + 256; r = 8'(sum % 256); c = (a < b); end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h03: r = 8'($signed(a) >>> b);
            6'h02: r = a >> b;
            default: r = 8'h00;
        endcase
        return {c, r};
    endfunction

    function automatic logic [7:0] flags_ref(input logic [8:0] cr);
        return {5'b00000, cr[8], cr[7], (cr[7:0] == 8'h00)};
    endfunction

    // Stand-in for the real ALU, combinational from the registered operands.
    logic [8:0] alu_cr;
    always_comb begin
        alu_cr             = alu_ref(bus.o_alu_data_A, bus.o_alu_data_B, bus.o_alu_OP);
        bus.i_alu_result   = alu_cr[7:0];
        bus.i_alu_carry    = alu_cr[8];
        bus.i_alu_negative = alu_cr[7];
        bus.i_alu_zero     = (alu_cr[7:0] == 8'h00);
    end

    always @(negedge clk) begin
        if (bus.o_tx_start === 1'b1) pulse_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'($urandom);
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_A"},     32'(bus.o_alu_data_A), 32'h0);
        check({tag, "_B"},     32'(bus.o_alu_data_B), 32'h0);
        check({tag, "_OP"},    32'(bus.o_alu_OP),     32'h0);
        check({tag, "_data"},  32'(bus.o_tx_data),    32'h0);
        check({tag, "_start"}, 32'(bus.o_tx_start),   32'h0);
        check({tag, "_state"}, 32'(bus.o_dbg_state),  32'(S_WAIT_A));
    endtask

    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] opb, input bit inject_rx, input bit stray_tx);
        logic [8:0] cr;
        cr = alu_ref(a, b, opb[5:0]);
        send_byte(a);
        if (stray_tx) pulse_tx_done();
        send_byte(b);
        send_byte(opb);
        check({tag, "_A"},  32'(bus.o_alu_data_A), 32'(a));
        check({tag, "_B"},  32'(bus.o_alu_data_B), 32'(b));
        check({tag, "_OP"}, 32'(bus.o_alu_OP),     32'(opb % 8'd64));
        check({tag, "_start_n1"}, 32'(bus.o_tx_start), 32'h0);
        @(negedge clk);
        check({tag, "_start_n2"}, 32'(bus.o_tx_start), 32'h1);
        check({tag, "_res"},      32'(bus.o_tx_data),  32'(cr[7:0]));
        exp_pulses++;
        @(negedge clk);
        check({tag, "_start_n3"}, 32'(bus.o_tx_start), 32'h0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (inject_rx) send_byte(8'hAA);
        check({tag, "_res_hold"}, 32'(bus.o_tx_data), 32'(cr[7:0]));
        pulse_tx_done();
`ifdef UART_ALU_IF_FLAGS_EN
        check({tag, "_flg_start"}, 32'(bus.o_tx_start), 32'h1);
        check({tag, "_flg"},       32'(bus.o_tx_data),  32'(flags_ref(cr)));
        exp_pulses++;
        @(negedge clk);
        check({tag, "_flg_start_n"}, 32'(bus.o_tx_start), 32'h0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        pulse_tx_done();
`endif
        check({tag, "_idle"},    32'(bus.o_dbg_state),  32'(S_WAIT_A));
        check({tag, "_A_hold"},  32'(bus.o_alu_data_A), 32'(a));
        check({tag, "_OP_hold"}, 32'(bus.o_alu_OP),     32'(opb % 8'd64));
    endtask

    initial begin
        logic [5:0] ops [8];
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};

        rst           = 1'b1;
        bus.i_rx_data = 8'h00;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_frame("add_5_3",   8'h05, 8'h03, 8'h20, 1'b0, 1'b0);
        run_frame("add_neg",   8'h7F, 8'h01, 8'h20, 1'b0, 1'b0);
        run_frame("sub_zero",  8'h03, 8'h03, 8'h22, 1'b0, 1'b0);
        run_frame("and_mask",  8'hF0, 8'h0F, 8'hE4, 1'b0, 1'b0);
        run_frame("rx_ignore", 8'h01, 8'h01, 8'h20, 1'b1, 1'b0);
        run_frame("after_ign", 8'h01, 8'h01, 8'h20, 1'b0, 1'b1);

        // Reset mid-frame with a coincident rx pulse must win.
        send_byte(8'h11);
        check("partial_state", 32'(bus.o_dbg_state),  32'(S_WAIT_B));
        check("partial_A",     32'(bus.o_alu_data_A), 32'h11);
        @(negedge clk);
        rst           = 1'b1;
        bus.i_rx_data = 8'h55;
        bus.i_rx_done = 1'b1;
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        check_all_zero("rst_wait_b");
        rst           = 1'b0;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        run_frame("or_post_rst", 8'h02, 8'h02, 8'h25, 1'b0, 1'b0);

        // Reset while waiting for the transmitter, with a coincident tx_done.
        send_byte(8'h40);
        send_byte(8'h02);
        send_byte(8'h20);
        @(negedge clk);
        check("pre_rst_start", 32'(bus.o_tx_start), 32'h1);
        check("pre_rst_res",   32'(bus.o_tx_data),  32'h42);
        exp_pulses++;
        @(negedge clk);
        rst           = 1'b1;
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        check_all_zero("rst_tx_res");
        rst           = 1'b0;
        bus.i_tx_done = 1'b0;

        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra, rb, rop;
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
            run_frame("rand", ra, rb, rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("tx_pulse_count", 32'(pulse_count), 32'(exp_pulses));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
